// File: rtl/mem_align_seq.sv
// Misaligned-access sequencer between EX/MEM and MEM. With `MEM_ALIGN_SPLIT_EN defined, misaligned
// H/W accesses are split into byte beats; otherwise they are flagged and suppressed.
module mem_align_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       RD2_EXEMEM_out,
  input  logic [1:0]        Mem_Control,
  input  logic [2:0]        funct3,
  input  logic [31:0]       Mem_Read_Data,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [31:0]       Mem_Write_Data,
  output logic [1:0]        Mem_Control_out,
  output logic [2:0]        Mem_funct3,
  output logic [31:0]       Read_Data,
  output logic              stall,
  output logic              misaligned
);

  logic is_half_s;
  logic is_word_s;
  logic mis_s;

  // Access size decode and misalignment detection
  always_comb begin
    is_half_s = 1'b0;
    is_word_s = 1'b0;
    case (funct3)
      3'b001, 3'b101: is_half_s = 1'b1;
      3'b010:         is_word_s = 1'b1;
      default: begin
        is_half_s = 1'b0;
        is_word_s = 1'b0;
      end
    endcase
    mis_s = Mem_Control[0] & ((is_half_s & Address[0]) |
                              (is_word_s & (Address[1:0] != 2'b00)));
  end

`ifdef MEM_ALIGN_SPLIT_EN

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  state_t      state_r;
  logic [1:0]  k_r;
  logic [23:0] buf_r;
  logic [1:0]  beat_s;
  logic [1:0]  last_s;
  logic        active_s;
  logic [7:0]  store_byte_s;
  logic [15:0] half_s;

  // Current beat index and store byte lane for that beat
  always_comb begin
    beat_s   = (state_r == SPLIT) ? k_r : 2'd0;
    last_s   = is_word_s ? 2'd3 : 2'd1;
    active_s = (state_r == SPLIT) | mis_s;
    half_s   = {Mem_Read_Data[7:0], buf_r[7:0]};
    case (beat_s)
      2'd0:    store_byte_s = RD2_EXEMEM_out[7:0];
      2'd1:    store_byte_s = RD2_EXEMEM_out[15:8];
      2'd2:    store_byte_s = RD2_EXEMEM_out[23:16];
      2'd3:    store_byte_s = RD2_EXEMEM_out[31:24];
      default: store_byte_s = 8'h00;
    endcase
  end

  // Split FSM, beat counter and load byte buffer (the last byte is never buffered)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= 2'd0;
      buf_r   <= 24'h000000;
    end else begin
      case (state_r)
        IDLE: begin
          if (mis_s) begin
            state_r     <= SPLIT;
            k_r         <= 2'd1;
            buf_r[7:0]  <= Mem_Read_Data[7:0];
          end
        end
        SPLIT: begin
          if (k_r == last_s) begin
            state_r <= IDLE;
            k_r     <= 2'd0;
          end else begin
            k_r <= k_r + 2'd1;
            case (k_r)
              2'd1:    buf_r[15:8]  <= Mem_Read_Data[7:0];
              2'd2:    buf_r[23:16] <= Mem_Read_Data[7:0];
              default: buf_r        <= buf_r;
            endcase
          end
        end
        default: begin
          state_r <= IDLE;
          k_r     <= 2'd0;
        end
      endcase
    end
  end

  // Output steering: pass-through unless a split is in progress
  always_comb begin
    Mem_Address     = Address;
    Mem_Write_Data  = RD2_EXEMEM_out;
    Mem_Control_out = Mem_Control;
    Mem_funct3      = funct3;
    Read_Data       = Mem_Read_Data;
    stall           = 1'b0;
    misaligned      = 1'b0;
    if (active_s) begin
      Mem_Address     = Address + ADDR_W'(beat_s);
      Mem_Control_out = {Mem_Control[1], 1'b1};
      Mem_funct3      = Mem_Control[1] ? 3'b000 : 3'b100;
      Mem_Write_Data  = {24'h000000, store_byte_s};
      stall           = (beat_s != last_s);
      if (Mem_Control[1]) begin
        Read_Data = 32'h00000000;
      end else if (is_word_s) begin
        Read_Data = {Mem_Read_Data[7:0], buf_r};
      end else if (funct3 == 3'b001) begin
        Read_Data = {{16{half_s[15]}}, half_s};
      end else begin
        Read_Data = {16'h0000, half_s};
      end
    end else begin
      stall = 1'b0;
    end
    if (!rst_n) begin
      Mem_Control_out = 2'b00;
      stall           = 1'b0;
    end else begin
      misaligned = 1'b0;
    end
  end

`else

  // No sequential state in this build; the clock is intentionally unused
  logic unused_clk_s;
  assign unused_clk_s = clk;

  // Suppress and flag misaligned accesses, pass everything else through
  always_comb begin
    Mem_Address     = Address;
    Mem_Write_Data  = RD2_EXEMEM_out;
    Mem_Control_out = Mem_Control;
    Mem_funct3      = funct3;
    Read_Data       = Mem_Read_Data;
    stall           = 1'b0;
    misaligned      = mis_s & rst_n;
    if (mis_s) begin
      Mem_Control_out = 2'b00;
      Read_Data       = 32'h00000000;
    end else begin
      Read_Data = Mem_Read_Data;
    end
    if (!rst_n) begin
      Mem_Control_out = 2'b00;
    end else begin
      stall = 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_mem_align_seq.sv
// Directed + randomized bench for mem_align_seq with a byte-array MEM-stage model
// and a shadow memory used as the reference.
`timescale 1ns/1ps
module tb_mem_align_seq;

`ifdef MEM_ALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] RD2_EXEMEM_out;
  logic [1:0]  Mem_Control;
  logic [2:0]  funct3;
  logic [31:0] Mem_Read_Data;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_Data;
  logic [1:0]  Mem_Control_out;
  logic [2:0]  Mem_funct3;
  logic [31:0] Read_Data;
  logic        stall;
  logic        misaligned;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        mem_clr;
  logic [7:0]  rb0, rb1, rb2, rb3;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_align_seq #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .RD2_EXEMEM_out(RD2_EXEMEM_out),
    .Mem_Control(Mem_Control), .funct3(funct3), .Mem_Read_Data(Mem_Read_Data),
    .Mem_Address(Mem_Address), .Mem_Write_Data(Mem_Write_Data),
    .Mem_Control_out(Mem_Control_out), .Mem_funct3(Mem_funct3),
    .Read_Data(Read_Data), .stall(stall), .misaligned(misaligned)
  );

  // MEM stage: combinational load with extension, 4 KiB aliased byte array
  always_comb begin
    rb0 = mem[Mem_Address[11:0]];
    rb1 = mem[Mem_Address[11:0] + 12'd1];
    rb2 = mem[Mem_Address[11:0] + 12'd2];
    rb3 = mem[Mem_Address[11:0] + 12'd3];
    case (Mem_funct3)
      3'b000:  Mem_Read_Data = {{24{rb0[7]}}, rb0};
      3'b100:  Mem_Read_Data = {24'h0, rb0};
      3'b001:  Mem_Read_Data = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  Mem_Read_Data = {16'h0, rb1, rb0};
      default: Mem_Read_Data = {rb3, rb2, rb1, rb0};
    endcase
  end

  // MEM stage: store on Mem_Control_out == 11
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (Mem_Control_out == 2'b11) begin
      case (Mem_funct3)
        3'b000: mem[Mem_Address[11:0]] <= Mem_Write_Data[7:0];
        3'b001: begin
          mem[Mem_Address[11:0]]         <= Mem_Write_Data[7:0];
          mem[Mem_Address[11:0] + 12'd1] <= Mem_Write_Data[15:8];
        end
        3'b010: begin
          mem[Mem_Address[11:0]]         <= Mem_Write_Data[7:0];
          mem[Mem_Address[11:0] + 12'd1] <= Mem_Write_Data[15:8];
          mem[Mem_Address[11:0] + 12'd2] <= Mem_Write_Data[23:16];
          mem[Mem_Address[11:0] + 12'd3] <= Mem_Write_Data[31:24];
        end
        default: ;
      endcase
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    if (f3 == 3'b010) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = ref_mem[12'(addr + 32'(i))];
    case (f3)
      3'b000:  return {{24{b[0][7]}}, b[0]};
      3'b100:  return {24'h0, b[0]};
      3'b001:  return {{16{b[1][7]}}, b[1], b[0]};
      3'b101:  return {16'h0, b[1], b[0]};
      default: return {b[3], b[2], b[1], b[0]};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    int n;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
    for (int i = 0; i < n; i++) ref_mem[12'(addr + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem();
    int diff;
    diff = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_contents", 32'(diff), 32'd0);
  endtask

  // One access from EX/MEM: split into beats when misaligned and splitting is built in
  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic en, output logic [31:0] rd);
    int n;
    logic mis, do_split;
    logic [31:0] exp_rd;
    n        = size_of(f3);
    mis      = en && (n > 1) && ((addr & 32'(n - 1)) != 32'd0);
    do_split = SPLIT_EN && mis;
    exp_rd   = ref_load(addr, f3);
    rd       = 32'h0;
    Address = addr; RD2_EXEMEM_out = wd; Mem_Control = {wr, en}; funct3 = f3;
    if (do_split) begin
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        chk("beat_addr", Mem_Address, addr + 32'(k));
        chk("beat_stall", 32'(stall), (k < n - 1) ? 32'd1 : 32'd0);
        chk("beat_ctrl", 32'(Mem_Control_out), wr ? 32'd3 : 32'd1);
        chk("beat_f3", 32'(Mem_funct3), wr ? 32'd0 : 32'd4);
        chk("beat_misaligned", 32'(misaligned), 32'd0);
        if (wr) begin
          chk("beat_wdata", Mem_Write_Data, (wd >> (8 * k)) & 32'hFF);
          chk("store_rdata", Read_Data, 32'd0);
        end else if (k == n - 1) begin
          chk("split_load", Read_Data, exp_rd);
        end
        rd = Read_Data;
        @(posedge clk); #1;
      end
    end else begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'd0);
      chk("misaligned", 32'(misaligned), 32'(mis));
      chk("addr", Mem_Address, addr);
      if (mis) begin
        chk("suppr_ctrl", 32'(Mem_Control_out), 32'd0);
        chk("suppr_rdata", Read_Data, 32'd0);
      end else begin
        chk("ctrl", 32'(Mem_Control_out), 32'({wr, en}));
        chk("f3", 32'(Mem_funct3), 32'(f3));
        chk("rdata", Read_Data, exp_rd);
        if (wr) chk("wdata", Mem_Write_Data, wd);
      end
      rd = Read_Data;
      @(posedge clk); #1;
    end
    if (wr && en && !(mis && !SPLIT_EN)) ref_store(addr, f3, wd);
    chk_mem();
  endtask

  initial begin
    logic [31:0] rd;
    logic        wr, en;
    logic [2:0]  f3;
    logic [31:0] addr;
    rst_n = 1'b0; mem_clr = 1'b1;
    Address = 32'h0; RD2_EXEMEM_out = 32'hCAFEF00D; Mem_Control = 2'b11; funct3 = 3'b010;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    chk("rst_ctrl", 32'(Mem_Control_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    @(posedge clk); #1;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_ctrl2", 32'(Mem_Control_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; Mem_Control = 2'b00;
    chk_mem();

    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, rd);
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, rd);
    chk("lw_aligned", rd, 32'hDEADBEEF);
    do_access(1'b1, 3'b010, 32'h100, 32'h0, 1'b1, rd);
    do_access(1'b1, 3'b010, 32'h101, 32'h11223344, 1'b1, rd);
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, rd);
    chk("lw_after_sw", rd, SPLIT_EN ? 32'h22334400 : 32'h0);

    do_access(1'b1, 3'b000, 32'h103, 32'h34, 1'b1, rd);
    do_access(1'b1, 3'b000, 32'h104, 32'hF2, 1'b1, rd);
    do_access(1'b0, 3'b001, 32'h103, 32'h0, 1'b1, rd);
    chk("lh_mis", rd, SPLIT_EN ? 32'hFFFFF234 : 32'h0);
    do_access(1'b0, 3'b101, 32'h103, 32'h0, 1'b1, rd);
    chk("lhu_mis", rd, SPLIT_EN ? 32'h0000F234 : 32'h0);

    do_access(1'b1, 3'b000, 32'hFFFFFFFF, 32'hA1, 1'b1, rd);
    do_access(1'b1, 3'b010, 32'h0, 32'h55D3C2B2, 1'b1, rd);
    do_access(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, rd);
    chk("lw_wrap", rd, SPLIT_EN ? 32'hD3C2B2A1 : 32'h0);

    do_access(1'b1, 3'b001, 32'h201, 32'h0000ABCD, 1'b1, rd);
    do_access(1'b1, 3'b001, 32'h200, 32'h0, 1'b1, rd);

`ifdef MEM_ALIGN_SPLIT_EN
    // Reset during beat 2 of a misaligned SW
    Address = 32'h201; RD2_EXEMEM_out = 32'h11223344; Mem_Control = 2'b11; funct3 = 3'b010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstsplit_addr", Mem_Address, 32'h201 + 32'(k));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstsplit_ctrl", 32'(Mem_Control_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; Address = 32'h200; Mem_Control = 2'b01;
    ref_mem[12'h201] = 8'h44;
    ref_mem[12'h202] = 8'h33;
    @(negedge clk);
    chk("rstsplit_stall", 32'(stall), 32'd0);
    chk("rstsplit_idle_addr", Mem_Address, 32'h200);
    chk("rstsplit_lw", Read_Data, 32'h00334400);
    @(posedge clk); #1;
    chk_mem();
`endif

    for (int it = 0; it < 80; it++) begin
      wr   = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 7) != 0);
      f3   = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                         : ($urandom & 32'h00000FFF);
      do_access(wr, f3, addr, $urandom, en, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
